// File: rtl/uart_tx_engine.sv
// UART 8N1 transmit serializer with a divide-by-BAUD_DIV bit timer.
// Define UART_TX_PARITY_EN to insert a parity bit (PARITY_ODD selects odd parity).
module uart_tx_engine #(
    parameter int BAUD_DIV = 5208,
    parameter int CNT_W    = 16
`ifdef UART_TX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(BAUD_DIV - 1);

    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [2:0]       idx_q, idx_n;
    logic [7:0]       shreg_q, shreg_n;
    logic             tx_q, tx_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;
    logic             bit_end;
`ifdef UART_TX_PARITY_EN
    logic             par_q, par_n;
`endif

    assign bit_end = (cnt_q == LAST);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
        state_n = state_q;
        cnt_n   = bit_end ? '0 : cnt_q + CNT_W'(1);
        idx_n   = idx_q;
        shreg_n = shreg_q;
        tx_n    = tx_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n   = par_q;
`endif

        unique case (state_q)
            IDLE: begin
                cnt_n  = '0;
                tx_n   = 1'b1;
                busy_n = 1'b0;
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    idx_n   = 3'd0;
                    tx_n    = shreg_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_n = shreg_q >> 1;
                    idx_n   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
                        tx_n    = par_q ^ PARITY_ODD;
`else
                        state_n = STOP;
                        tx_n    = 1'b1;
`endif
                    end else begin
                        tx_n = shreg_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                    tx_n    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    tx_n    = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Acceptance happens in IDLE or on the final stop-bit edge, so held requests chain frames gap-free.
        if (tx_start && (state_q == IDLE || (state_q == STOP && bit_end))) begin
            state_n = START;
            cnt_n   = '0;
            idx_n   = 3'd0;
            shreg_n = tx_data;
            tx_n    = 1'b0;
            busy_n  = 1'b1;
`ifdef UART_TX_PARITY_EN
            par_n   = ^tx_data;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shreg_q <= 8'h00;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q <= state_n;
            cnt_q   <= cnt_n;
            idx_q   <= idx_n;
            shreg_q <= shreg_n;
            tx_q    <= tx_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_n;
`endif
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine at BAUD_DIV=4: table of frames plus
// hand-written reset, busy-rejection, back-to-back and mid-frame-reset sequences.
module tb_uart_tx_engine;

    localparam int BD = 4;
`ifdef UART_TX_PARITY_EN
    localparam bit PODD = 1'b0;
    localparam int NB   = 11;
`else
    localparam int NB   = 10;
`endif
    localparam int FRAME = NB * BD;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    int checks   = 0;
    int failures = 0;

    uart_tx_engine #(
        .BAUD_DIV(BD),
        .CNT_W   (4)
`ifdef UART_TX_PARITY_EN
        ,
        .PARITY_ODD(PODD)
`endif
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tx_start(tx_start),
        .tx_data (tx_data),
        .tx      (tx),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    // frame[0] = start bit, frame[8:1] = data LSB first, frame[9] = stop bit.
    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_bit(input logic [9:0] f, input int k, input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        if (k == 9)  return (^d) ^ PODD;
        if (k == 10) return f[9];
`endif
        return f[k];
    endfunction

    // Accept a byte: drive the request, take the edge, then scramble tx_data.
    task automatic accept(input logic [7:0] d);
        tx_start = 1'b1;
        tx_data  = d;
        step();
        tx_start = 1'b0;
        tx_data  = ~d;
    endtask

    // Check one full frame starting just after its acceptance edge.
    task automatic run_frame(input string name, input logic [7:0] d, input logic [9:0] f,
                             input logic done_first, input int inj_cyc, input logic [7:0] inj_data);
        for (int c = 0; c < FRAME; c++) begin
            check({name, "_tx"}, 32'(tx), 32'(exp_bit(f, c / BD, d)));
            check({name, "_busy_done"}, {30'd0, tx_busy, tx_done},
                  {30'd0, 1'b1, (c == 0) ? done_first : 1'b0});
            if (c == inj_cyc) begin
                tx_start = 1'b1;
                tx_data  = inj_data;
            end else if (c == inj_cyc + 1) begin
                tx_start = 1'b0;
                tx_data  = 8'h00;
            end
            step();
        end
    endtask

    task automatic check_end(input string name);
        check({name, "_end"}, {29'd0, tx, tx_busy, tx_done}, {29'd0, 1'b1, 1'b0, 1'b1});
        step();
        check({name, "_after"}, {29'd0, tx, tx_busy, tx_done}, {29'd0, 1'b1, 1'b0, 1'b0});
    endtask

    initial begin
        vecs[0] = '{8'hA5, 10'b1101001010};
        vecs[1] = '{8'h3C, 10'b1001111000};
        vecs[2] = '{8'h00, 10'b1000000000};
        vecs[3] = '{8'hFF, 10'b1111111110};
        vecs[4] = '{8'h5A, 10'b1010110100};
        vecs[5] = '{8'h01, 10'b1000000010};
        vecs[6] = '{8'h80, 10'b1100000000};
        vecs[7] = '{8'h07, 10'b1000001110};

        // Reset overrides a pending request, then idle for 20 cycles.
        reset    = 1'b1;
        tx_start = 1'b1;
        tx_data  = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_hold", {29'd0, tx, tx_busy, tx_done}, {29'd0, 1'b1, 1'b0, 1'b0});
        end
        tx_start = 1'b0;
        reset    = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check("idle", {29'd0, tx, tx_busy, tx_done}, {29'd0, 1'b1, 1'b0, 1'b0});
        end

        // Table-driven single frames.
        foreach (vecs[i]) begin
            accept(vecs[i].data);
            run_frame($sformatf("frame_%02h", vecs[i].data), vecs[i].data, vecs[i].frame, 1'b0, -5, 8'h00);
            check_end($sformatf("frame_%02h", vecs[i].data));
            step();
        end

        // Busy rejection: a request at cycle 10 must not disturb or queue.
        accept(8'h3C);
        run_frame("busy_rej", 8'h3C, vecs[1].frame, 1'b0, 10, 8'hFF);
        check_end("busy_rej");
        for (int i = 0; i < FRAME; i++) begin
            check("busy_rej_no_second", {29'd0, tx, tx_busy, tx_done}, {29'd0, 1'b1, 1'b0, 1'b0});
            step();
        end

        // Back-to-back with tx_start held high: 00 then FF, no idle gap.
        tx_start = 1'b1;
        tx_data  = 8'h00;
        step();
        tx_data = 8'hFF;
        run_frame("b2b_first", 8'h00, vecs[2].frame, 1'b0, -5, 8'h00);
        tx_start = 1'b0;
        tx_data  = 8'h55;
        run_frame("b2b_second", 8'hFF, vecs[3].frame, 1'b1, -5, 8'h00);
        check_end("b2b");

        // Reset at cycle 17 of a frame aborts it without tx_done.
        step();
        accept(8'hC3);
        for (int c = 0; c < 17; c++) step();
        check("pre_reset_busy", 32'(tx_busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_reset", {29'd0, tx, tx_busy, tx_done}, {29'd0, 1'b1, 1'b0, 1'b0});
        for (int i = 0; i < 12; i++) begin
            step();
            check("post_reset_idle", {29'd0, tx, tx_busy, tx_done}, {29'd0, 1'b1, 1'b0, 1'b0});
        end
        accept(8'h5A);
        run_frame("post_reset_5A", 8'h5A, vecs[4].frame, 1'b0, -5, 8'h00);
        check_end("post_reset_5A");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
